// File: rtl/xmt_pkg.sv
// Shared types and constants for the UART transmit control unit.
package xmt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAITING,
        SENDING
    } xmt_state_t;

    localparam int WORD_SIZE = 8;
    localparam int BC_MAX    = WORD_SIZE + 1;

endpackage

// File: rtl/xmt_control_unit_if.sv
// Host/datapath handshake bundle for xmt_control_unit.
// The abort signal exists only when XMT_CTRL_ABORT_EN is defined.
interface xmt_control_unit_if;

    logic Load_XMT_datareg;
    logic Byte_ready;
    logic T_byte;
    logic BC_lt_BCmax;
    logic Load_XMT_DR;
    logic Load_XMT_shftreg;
    logic start;
    logic shift;
    logic clear;
    logic busy;
`ifdef XMT_CTRL_ABORT_EN
    logic abort;
`endif

    // Host and datapath side: issues requests, consumes strobes.
    modport master (
        output Load_XMT_datareg,
        output Byte_ready,
        output T_byte,
        output BC_lt_BCmax,
        input  Load_XMT_DR,
        input  Load_XMT_shftreg,
        input  start,
        input  shift,
        input  clear,
        input  busy
`ifdef XMT_CTRL_ABORT_EN
        ,
        output abort
`endif
    );

    // Control unit side.
    modport slave (
        input  Load_XMT_datareg,
        input  Byte_ready,
        input  T_byte,
        input  BC_lt_BCmax,
        output Load_XMT_DR,
        output Load_XMT_shftreg,
        output start,
        output shift,
        output clear,
        output busy
`ifdef XMT_CTRL_ABORT_EN
        ,
        input  abort
`endif
    );

endinterface

// File: rtl/xmt_bit_timer.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 while enabled and holds at 0 otherwise.
module xmt_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic Clock,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge Clock) begin
        if (rst || !en) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/xmt_control_unit.sv
// UART transmit control FSM: turns host handshakes into datapath strobes and
// paces one shift per bit period. Optional frame abort via XMT_CTRL_ABORT_EN.
module xmt_control_unit
    import xmt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 Clock,
    input  logic                 rst,
    xmt_control_unit_if.slave    bus
);

    xmt_state_t state_reg;
    xmt_state_t state_next;

    logic abort_req;
    logic tick;
    logic timer_en;

    logic load_dr;
    logic load_shftreg;
    logic start_pulse;
    logic shift_pulse;
    logic clear_pulse;

`ifdef XMT_CTRL_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // Timer only runs in SENDING; an abort zeroes it on the same edge we leave.
    assign timer_en = (state_reg == SENDING) && !abort_req && !rst;

    xmt_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .Clock (Clock),
        .rst   (rst),
        .en    (timer_en),
        .tick  (tick)
    );

    always_comb begin
        state_next   = state_reg;
        load_dr      = 1'b0;
        load_shftreg = 1'b0;
        start_pulse  = 1'b0;
        shift_pulse  = 1'b0;
        clear_pulse  = 1'b0;
        if (rst) begin
            state_next = IDLE;
        end else begin
            load_dr = bus.Load_XMT_datareg;
            unique case (state_reg)
                IDLE: begin
                    // A simultaneous data-register load wins; Byte_ready is dropped.
                    if (bus.Byte_ready && !bus.Load_XMT_datareg) begin
                        load_shftreg = 1'b1;
                        state_next   = WAITING;
                    end
                end
                WAITING: begin
                    if (abort_req) begin
                        clear_pulse = 1'b1;
                        state_next  = IDLE;
                    end else if (bus.T_byte) begin
                        start_pulse = 1'b1;
                        state_next  = SENDING;
                    end
                end
                SENDING: begin
                    if (abort_req) begin
                        clear_pulse = 1'b1;
                        state_next  = IDLE;
                    end else if (tick) begin
                        if (bus.BC_lt_BCmax) begin
                            shift_pulse = 1'b1;
                        end else begin
                            clear_pulse = 1'b1;
                            state_next  = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign bus.Load_XMT_DR      = load_dr;
    assign bus.Load_XMT_shftreg = load_shftreg;
    assign bus.start            = start_pulse;
    assign bus.shift            = shift_pulse;
    assign bus.clear            = clear_pulse;
    assign bus.busy             = !rst && (state_reg != IDLE);

endmodule

// File: tb/tb_xmt_control_unit.sv
// Self-checking bench for xmt_control_unit with a frame-schedule reference
// model and a behavioural transmit datapath driven by the DUT strobes.
module tb_xmt_control_unit;
    import xmt_pkg::*;

    localparam int N = 4;
`ifdef XMT_CTRL_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xmt_control_unit_if bus_if ();

    xmt_control_unit #(
        .CLKS_PER_BIT(N)
    ) dut (
        .Clock (clk),
        .rst   (rst),
        .bus   (bus_if.slave)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc_cnt = 0;

    // Reference model: 0 idle, 1 byte loaded, 2 sending (frame started at t0).
    int         m_mode;
    int         t0;
    logic [7:0] m_dr;
    logic [7:0] m_byte;

    // Behavioural datapath fed by the DUT strobes.
    logic [7:0] dp_dr;
    logic [8:0] dp_sh;
    int         dp_bc;

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_total++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc_cnt, obs, expv);
        end
    endtask

    task automatic cyc(input logic r, input logic ld, input logic br,
                       input logic tb, input logic ab, input logic [7:0] db);
        logic e_ldr, e_lsh, e_st, e_sh, e_cl, e_busy, e_bit;
        logic s_ldr, s_lsh, s_st, s_sh, s_cl;
        logic abv;
        int   d;
        int   j;
        abv = ab && ABORT_EN;
        rst = r;
        bus_if.Load_XMT_datareg = ld;
        bus_if.Byte_ready       = br;
        bus_if.T_byte           = tb;
`ifdef XMT_CTRL_ABORT_EN
        bus_if.abort            = ab;
`endif
        @(negedge clk);
        d      = cyc_cnt - t0;
        e_ldr  = 1'b0;
        e_lsh  = 1'b0;
        e_st   = 1'b0;
        e_sh   = 1'b0;
        e_cl   = 1'b0;
        e_busy = !r && (m_mode != 0);
        if (!r) begin
            e_ldr = ld;
            if (m_mode == 0) begin
                e_lsh = br && !ld;
            end else if (m_mode == 1) begin
                if (abv) e_cl = 1'b1;
                else     e_st = tb;
            end else begin
                if (abv || d == 10 * N) e_cl = 1'b1;
                else if (d % N == 0 && d / N >= 1 && d / N <= 9) e_sh = 1'b1;
            end
        end
        chk("Load_XMT_DR",      bus_if.Load_XMT_DR,      e_ldr);
        chk("Load_XMT_shftreg", bus_if.Load_XMT_shftreg, e_lsh);
        chk("start",            bus_if.start,            e_st);
        chk("shift",            bus_if.shift,            e_sh);
        chk("clear",            bus_if.clear,            e_cl);
        chk("busy",             bus_if.busy,             e_busy);
        if (!r && m_mode == 2 && d >= 1) begin
            // Frame on the line: start bit, 8 data bits LSB first, stop bit.
            j = (d - 1) / N;
            if (j == 0)      e_bit = 1'b0;
            else if (j >= 9) e_bit = 1'b1;
            else             e_bit = m_byte[j-1];
            chk("serial_out", dp_sh[0], e_bit);
        end
        s_ldr = bus_if.Load_XMT_DR;
        s_lsh = bus_if.Load_XMT_shftreg;
        s_st  = bus_if.start;
        s_sh  = bus_if.shift;
        s_cl  = bus_if.clear;
        @(posedge clk);
        #1;
        if (r) begin
            m_mode = 0;
            m_dr   = 8'h00;
        end else begin
            if (m_mode == 0) begin
                if (br && !ld) begin
                    m_mode = 1;
                    m_byte = m_dr;
                end
            end else if (m_mode == 1) begin
                if (abv) m_mode = 0;
                else if (tb) begin
                    m_mode = 2;
                    t0     = cyc_cnt;
                end
            end else begin
                if (abv || d == 10 * N) m_mode = 0;
            end
            if (ld) m_dr = db;
        end
        cyc_cnt++;
        if (r) begin
            dp_dr = 8'h00;
            dp_sh = '1;
            dp_bc = 0;
        end else begin
            if (s_lsh) dp_sh = {dp_dr, 1'b1};
            if (s_ldr) dp_dr = db;
            if (s_st)  dp_sh[0] = 1'b0;
            if (s_sh) begin
                dp_sh = {1'b1, dp_sh[8:1]};
                dp_bc++;
            end
            if (s_cl) dp_bc = 0;
        end
        bus_if.BC_lt_BCmax = (dp_bc < BC_MAX);
    endtask

    initial begin
        m_mode = 0;
        t0     = 0;
        m_dr   = 8'h00;
        m_byte = 8'h00;
        dp_dr  = 8'h00;
        dp_sh  = '1;
        dp_bc  = 0;
        bus_if.BC_lt_BCmax = 1'b1;

        // Reset
        repeat (3) cyc(1, 0, 0, 0, 0, 8'h00);
        // T_byte in IDLE is ignored
        cyc(0, 0, 0, 1, 0, 8'h00);
        cyc(0, 0, 0, 0, 0, 8'h00);
        // Full frame with 8'hA5
        cyc(0, 1, 0, 0, 0, 8'hA5);
        cyc(0, 0, 1, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 0, 8'h00);
        repeat (44) cyc(0, 0, 0, 0, 0, 8'h00);
        // Simultaneous load and Byte_ready in IDLE
        cyc(0, 1, 1, 0, 0, 8'h11);
        cyc(0, 0, 0, 1, 0, 8'h00);
        // Double buffering: send 8'h11 while loading 8'h3C
        cyc(0, 0, 1, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 0, 8'h00);
        repeat (10) cyc(0, 0, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 0, 8'h3C);
        cyc(0, 0, 1, 1, 0, 8'h00);
        repeat (35) cyc(0, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 0, 8'h00);
        repeat (44) cyc(0, 0, 0, 0, 0, 8'h00);
        // Reset mid-frame
        cyc(0, 1, 0, 0, 0, 8'h5A);
        cyc(0, 0, 1, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 0, 8'h00);
        repeat (15) cyc(0, 0, 0, 0, 0, 8'h00);
        repeat (2) cyc(1, 0, 0, 0, 0, 8'h00);
        repeat (3) cyc(0, 0, 0, 0, 0, 8'h00);
        // Abort at t+13 (only meaningful when the abort port exists)
        cyc(0, 1, 0, 0, 0, 8'hC3);
        cyc(0, 0, 1, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 0, 8'h00);
        repeat (12) cyc(0, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 0, 1, 8'h00);
        repeat (40) cyc(0, 0, 0, 0, 0, 8'h00);
        // Randomized traffic
        repeat (600) begin
            cyc(0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 60) == 0,
                8'($urandom));
        end
        repeat (45) cyc(0, 0, 0, 0, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/xmt_control_unit.md
# xmt_control_unit

UART transmitter control unit: the FSM that sequences the transmit datapath (data register, 9-bit shift register, bit counter) through load, start, shift and clear. It converts host handshakes (Load_XMT_datareg, Byte_ready, T_byte) into the datapath strobes, paces one shift per bit period with an internal baud divider, and ends the frame when the datapath's bit counter reports the word is done. Sits between the host bus interface and the transmit datapath, in the same clock domain.

## Interface
- CLKS_PER_BIT, 16: Clock cycles per serial bit. Legal range 2..65535.
- Clock  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- Load_XMT_datareg  in  1  host request to capture Data_Bus into the data register
- Byte_ready  in  1  host: data register holds a byte to move into the shift register
- T_byte  in  1  host: begin transmitting the loaded byte
- BC_lt_BCmax  in  1  datapath: bit count < 9, so frame bits remain
- abort  in  1  cancel the current frame; present only with XMT_CTRL_ABORT_EN
- Load_XMT_DR  out  1  datapath strobe: Data_Bus -> data register
- Load_XMT_shftreg  out  1  datapath strobe: {data register, 1'b1} -> shift register
- start  out  1  datapath strobe: shift register bit 0 := 0 (start bit)
- shift  out  1  datapath strobe: shift right one bit, backfill 1; bit count +1
- clear  out  1  datapath strobe: bit count := 0
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WAITING, SENDING. Strobes are Mealy (combinational from state and inputs), one cycle wide.
- IDLE
  - Load_XMT_DR = Load_XMT_datareg.
  - Byte_ready with Load_XMT_datareg low: Load_XMT_shftreg=1 -> WAITING.
  - Both high: only Load_XMT_DR asserts. Byte_ready is ignored that cycle; stay in IDLE.
- WAITING
  - Load_XMT_DR = Load_XMT_datareg (double buffering).
  - T_byte: start=1, bit timer := 0 -> SENDING.
- SENDING
  - Load_XMT_DR = Load_XMT_datareg.
  - Bit timer increments every cycle.
  - At timer == CLKS_PER_BIT-1, timer wraps to 0, then:
    - BC_lt_BCmax=1: shift=1.
    - BC_lt_BCmax=0: clear=1 -> IDLE.
- Byte_ready outside IDLE and T_byte outside WAITING are ignored (not queued).
- shift and clear are never high in the same cycle. start and shift are never high in the same cycle.
- Bit timer width: $clog2(CLKS_PER_BIT). It is held at 0 outside SENDING.

## Timing
- While rst=1: all outputs 0 in that cycle, state := IDLE, timer := 0.
- Reset mid-frame aborts with no clear pulse; the datapath is reset by the same rst.
- T_byte sampled at edge t (start=1 in cycle t):
  - shift pulses at t+k*CLKS_PER_BIT, for k=1..9.
  - clear at t+10*CLKS_PER_BIT.
  - busy falls at t+10*CLKS_PER_BIT+1.
- Serial line timing:
  - Start bit and each data bit last exactly CLKS_PER_BIT cycles.
  - Stop bit lasts at least CLKS_PER_BIT cycles.
- Byte_ready -> Load_XMT_shftreg: 0 cycles (same cycle). Earliest accepted T_byte is the next cycle.

## Configuration
- XMT_CTRL_ABORT_EN defined:
  - abort port exists.
  - abort=1 in WAITING or SENDING gives clear=1 that cycle -> IDLE, and suppresses shift/start that cycle.
  - abort in IDLE has no effect. rst has priority over abort.
- XMT_CTRL_ABORT_EN undefined: no abort port. A frame always runs to completion.

## Structure
- Package xmt_pkg holds:
  - typedef enum xmt_state_t {IDLE, WAITING, SENDING}
  - WORD_SIZE=8
  - BC_MAX=WORD_SIZE+1
- Sub-module xmt_bit_timer: divider counter.
  - Inputs: Clock, rst, en.
  - Output: tick, high when count == CLKS_PER_BIT-1.
- The control FSM stays in xmt_control_unit.

## Test plan
- Reset: rst=1 for 2 cycles while mid-SENDING -> all strobes 0, busy=0 next cycle, and no clear pulse.
- Full frame, CLKS_PER_BIT=4, Data 8'hA5: Load_XMT_datareg, then Byte_ready, then T_byte at cycle t -> shift at t+4,...,t+36; clear at t+40; Serial_out = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
- Simultaneous Load_XMT_datareg and Byte_ready in IDLE -> Load_XMT_DR=1, Load_XMT_shftreg=0, state stays IDLE.
- Double buffering: Load_XMT_datareg with 8'h3C during SENDING -> Load_XMT_DR pulses and the current frame is unaffected; next Byte_ready sends 8'h3C.
- Ignored inputs: T_byte in IDLE and Byte_ready in SENDING -> no start, no Load_XMT_shftreg pulse.
- With XMT_CTRL_ABORT_EN: abort at t+13 -> clear=1 at t+13, no shift at t+16, busy=0 at t+14.
